// File: rtl/jtag_idcode_reader_pkg.sv
// Shared types and constants for the JTAG IDCODE reader.
package jtag_pkg;

  localparam int TMS_TLR_CNT = 5;
  localparam int ID_WIDTH    = 32;
  localparam int SEQ_EDGES   = 43;

  // Last edge of the RTI/Select-DR/Capture-DR/Shift-DR walk, and last shift edge.
  localparam int NAV_LAST    = TMS_TLR_CNT + 4;
  localparam int SHIFT_LAST  = NAV_LAST + ID_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TLR,
    ST_NAV,
    ST_SHIFT,
    ST_EXIT,
    ST_FINISH
  } state_e;

  // TMS level the target must see at a given TCK rising edge (1-based).
  function automatic logic tms_for_edge(input logic [5:0] edge_num);
    logic val;
    val = 1'b0;
    if (edge_num <= 6'(TMS_TLR_CNT)) val = 1'b1;
    if (edge_num == 6'(TMS_TLR_CNT + 2)) val = 1'b1;
    if (edge_num == 6'(SHIFT_LAST) || edge_num == 6'(SHIFT_LAST + 1)) val = 1'b1;
    return val;
  endfunction

endpackage

// File: rtl/jtag_idcode_reader_if.sv
// Host request/result signals plus the JTAG chain pins of the IDCODE reader.
interface jtag_idcode_reader_if;
  import jtag_pkg::*;

  logic                start;
  logic                busy;
  logic                done;
  logic [ID_WIDTH-1:0] idcode;
  logic                lsb_ok;
  logic                open_chain;
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                tdo;

  // Host and target side: issues start, supplies TDO.
  modport master (
    output start, tdo,
    input  busy, done, idcode, lsb_ok, open_chain, tck, tms, tdi
  );

  // Reader side.
  modport slave (
    input  start, tdo,
    output busy, done, idcode, lsb_ok, open_chain, tck, tms, tdi
  );

endinterface

// File: rtl/jtag_idcode_reader_tck_gen.sv
// TCK divider: TCK_DIV clk low, TCK_DIV clk high, parked low when run=0.
// rise_stb/fall_stb are high in the clk cycle whose closing edge toggles tck.
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int            CW   = $clog2(TCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          half_end;

  // Count out each half period and flip tck at its end; idle resets the phase.
  always_comb begin
    half_end = run && (cnt_q == LAST);
    cnt_d    = cnt_q;
    tck_d    = tck_q;
    if (!run) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck      = tck_q;
  assign rise_stb = half_end && !tck_q;
  assign fall_stb = half_end && tck_q;

endmodule

// File: rtl/jtag_idcode_reader.sv
// Host-side JTAG initiator: resets the target TAP, walks it to Shift-DR,
// shifts out the 32-bit IDCODE LSB first and returns the TAP to Run-Test/Idle.
module jtag_idcode_reader
  import jtag_pkg::*;
#(
  parameter int   TCK_DIV  = 2,
  parameter logic TDI_FILL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  jtag_idcode_reader_if.slave bus
);

  state_e              state_q, state_d;
  logic [5:0]          edge_cnt_q, edge_cnt_d;
  logic [ID_WIDTH-1:0] shift_q, shift_d;
  logic [ID_WIDTH-1:0] idcode_q, idcode_d;
  logic                lsb_ok_q, lsb_ok_d;
  logic                open_chain_q, open_chain_d;
  logic                tms_q, tms_d;

  logic run, tck, rise_stb, fall_stb;
  logic accept, load_result, busy, done;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Phase changes happen on tck falls once the edge counter reaches each phase's last edge;
  // FINISH is entered on the clk after the final fall, when tck is low again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_TLR;
      ST_TLR:    if (fall_stb && edge_cnt_q == 6'(TMS_TLR_CNT)) state_d = ST_NAV;
      ST_NAV:    if (fall_stb && edge_cnt_q == 6'(NAV_LAST)) state_d = ST_SHIFT;
      ST_SHIFT:  if (fall_stb && edge_cnt_q == 6'(SHIFT_LAST)) state_d = ST_EXIT;
      ST_EXIT:   if (!tck && edge_cnt_q == 6'(SEQ_EDGES)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded controls: busy spans the whole run including FINISH, done marks FINISH.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_FINISH);
    run         = (state_q == ST_TLR) || (state_q == ST_NAV) ||
                  (state_q == ST_SHIFT) || (state_q == ST_EXIT);
    accept      = (state_q == ST_IDLE) && bus.start;
    load_result = (state_q == ST_EXIT) && (state_d == ST_FINISH);
  end

  // Edge counting, TDO capture on rises, TMS update on falls, result load into the
  // output registers only when the full sequence has completed.
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    shift_d      = shift_q;
    tms_d        = tms_q;
    idcode_d     = idcode_q;
    lsb_ok_d     = lsb_ok_q;
    open_chain_d = open_chain_q;

    if (accept) begin
      edge_cnt_d = '0;
      shift_d    = '0;
      tms_d      = 1'b1;
    end else begin
      if (rise_stb) begin
        edge_cnt_d = edge_cnt_q + 6'd1;
        if (state_q == ST_SHIFT) shift_d = {bus.tdo, shift_q[ID_WIDTH-1:1]};
      end
      if (fall_stb && edge_cnt_q != 6'(SEQ_EDGES)) begin
        tms_d = tms_for_edge(edge_cnt_q + 6'd1);
      end
    end

    if (load_result) begin
      idcode_d     = shift_q;
      lsb_ok_d     = shift_q[0];
      open_chain_d = (shift_q == {ID_WIDTH{1'b1}});
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_q   <= '0;
      shift_q      <= '0;
      tms_q        <= 1'b1;
      idcode_q     <= '0;
      lsb_ok_q     <= 1'b0;
      open_chain_q <= 1'b0;
    end else begin
      edge_cnt_q   <= edge_cnt_d;
      shift_q      <= shift_d;
      tms_q        <= tms_d;
      idcode_q     <= idcode_d;
      lsb_ok_q     <= lsb_ok_d;
      open_chain_q <= open_chain_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.idcode     = idcode_q;
  assign bus.lsb_ok     = lsb_ok_q;
  assign bus.open_chain = open_chain_q;
  assign bus.tck        = tck;
  assign bus.tms        = tms_q;
  assign bus.tdi        = TDI_FILL;

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Bench for jtag_idcode_reader: behavioural TAP target, cycle-count reference model,
// per-cycle compare process and directed plus randomized runs.
module tb_jtag_idcode_reader;
  import jtag_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  int          tdoMode = 0;
  logic [31:0] targetId = 32'h0;
  logic        tdoReg = 1'b1;
  logic        tdoVal;

  jtag_idcode_reader_if bus2();
  jtag_idcode_reader_if bus3();

  assign bus2.start = start && !sel;
  assign bus3.start = start && sel;
  assign bus2.tdo   = tdoVal;
  assign bus3.tdo   = tdoVal;

  jtag_idcode_reader #(.TCK_DIV(2), .TDI_FILL(1'b1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  jtag_idcode_reader #(.TCK_DIV(3), .TDI_FILL(1'b1)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  logic        obsTck, obsTms, obsTdi, obsBusy, obsDone, obsLsb, obsOpen;
  logic [31:0] obsIdcode;
  assign obsTck    = sel ? bus3.tck        : bus2.tck;
  assign obsTms    = sel ? bus3.tms        : bus2.tms;
  assign obsTdi    = sel ? bus3.tdi        : bus2.tdi;
  assign obsBusy   = sel ? bus3.busy       : bus2.busy;
  assign obsDone   = sel ? bus3.done       : bus2.done;
  assign obsLsb    = sel ? bus3.lsb_ok     : bus2.lsb_ok;
  assign obsOpen   = sel ? bus3.open_chain : bus2.open_chain;
  assign obsIdcode = sel ? bus3.idcode     : bus2.idcode;

  // ---------------- behavioural target: 16-state TAP + ID register ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
  } tap_e;

  function automatic tap_e tapNext(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PSDR;
      PSDR:    return m ? EX2DR : PSDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PSIR;
      PSIR:    return m ? EX2IR : PSIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  tap_e        tapState = TLR;
  logic [31:0] dr = 32'h0;
  int          presetReq = 0;
  int          presetSeen = 0;

  // Target TAP advances on tck rise; a pending preset drops it into Shift-IR first.
  always @(posedge obsTck) begin
    if (presetReq != presetSeen) begin
      tapState   = SHIR;
      presetSeen = presetReq;
    end
    if (tapState == CAPDR)     dr = targetId;
    else if (tapState == SHDR) dr = {obsTdi, dr[31:1]};
    tapState = tapNext(tapState, obsTms);
  end

  // Target drives TDO on tck fall while shifting; pulled high otherwise.
  always @(negedge obsTck) tdoReg <= (tapState == SHDR) ? dr[0] : 1'b1;

  assign tdoVal = (tdoMode == 1) ? 1'b1 : (tdoMode == 2) ? 1'b0 : tdoReg;

  // ---------------- reference model: cycle count since accepted start ----------------
  int          modelDiv;
  int          modelIdx;
  logic [31:0] expValue;
  assign modelDiv = sel ? 3 : 2;
  assign modelIdx = sel ? 1 : 0;
  assign expValue = (tdoMode == 1) ? 32'hFFFF_FFFF : (tdoMode == 2) ? 32'h0 : targetId;

  bit          modelActive = 1'b0;
  int          modelAge = 0;
  logic [31:0] expIdcode [2] = '{32'h0, 32'h0};
  logic        expLsb [2] = '{1'b0, 1'b0};
  logic        expOpen [2] = '{1'b0, 1'b0};
  logic        expTmsIdle [2] = '{1'b1, 1'b1};

  // A run lasts SEQ_EDGES full TCK periods plus two clk; done shows in its last cycle.
  always @(posedge clk) begin
    if (reset) begin
      modelActive = 1'b0;
      for (int i = 0; i < 2; i++) begin
        expIdcode[i]  = 32'h0;
        expLsb[i]     = 1'b0;
        expOpen[i]    = 1'b0;
        expTmsIdle[i] = 1'b1;
      end
    end else if (modelActive) begin
      if (modelAge == SEQ_EDGES * 2 * modelDiv + 1) begin
        modelActive          = 1'b0;
        expTmsIdle[modelIdx] = 1'b0;
      end else begin
        modelAge++;
        if (modelAge == SEQ_EDGES * 2 * modelDiv + 1) begin
          expIdcode[modelIdx] = expValue;
          expLsb[modelIdx]    = expValue[0];
          expOpen[modelIdx]   = (expValue == 32'hFFFF_FFFF);
        end
      end
    end else if (start) begin
      modelActive = 1'b1;
      modelAge    = 0;
    end
  end

  function automatic logic tmsRule(input int n);
    return (n >= 1 && n <= 5) || n == 7 || n == 41 || n == 42;
  endfunction

  // ---------------- checking ----------------
  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  bit          checkEn = 1'b0;
  bit          pinValid = 1'b0;
  bit          pinRti = 1'b0;
  logic [31:0] pinIdcode = 32'h0;
  logic        pinLsb = 1'b0;
  logic        pinOpen = 1'b0;
  int          pinLatency = 0;

  logic prevTck = 1'b0;
  logic tmsAtRise = 1'b0;
  int   riseIdx = 0;
  int   ca, cd;
  logic eTck, eBusy, eDone;

  // Compare every cycle on the falling clk edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      ca    = modelAge;
      cd    = modelDiv;
      eBusy = modelActive;
      eDone = modelActive && (ca == SEQ_EDGES * 2 * cd + 1);
      eTck  = modelActive && (ca >= cd) && (ca < SEQ_EDGES * 2 * cd) && (((ca - cd) % (2 * cd)) < cd);

      checkOutput("busy", 32'(obsBusy), 32'(eBusy));
      checkOutput("done", 32'(obsDone), 32'(eDone));
      checkOutput("tck", 32'(obsTck), 32'(eTck));
      checkOutput("tdi", 32'(obsTdi), 32'h1);
      checkOutput("idcode", obsIdcode, expIdcode[modelIdx]);
      checkOutput("lsb_ok", 32'(obsLsb), 32'(expLsb[modelIdx]));
      checkOutput("open_chain", 32'(obsOpen), 32'(expOpen[modelIdx]));

      if (modelActive && ca == 0) riseIdx = 0;
      if (obsTck && !prevTck) begin
        riseIdx++;
        tmsAtRise = obsTms;
        checkOutput($sformatf("tms_at_rise%0d", riseIdx), 32'(obsTms), 32'(tmsRule(riseIdx)));
      end else if (obsTck && prevTck) begin
        checkOutput("tms_stable_high", 32'(obsTms), 32'(tmsAtRise));
      end
      if (modelActive && ca < cd) checkOutput("tms_before_first_rise", 32'(obsTms), 32'h1);
      if (!modelActive) checkOutput("tms_idle", 32'(obsTms), 32'(expTmsIdle[modelIdx]));

      if (obsDone) begin
        checkOutput("rise_count", riseIdx, 32'd43);
        if (pinValid) begin
          checkOutput("latency", ca + 1, pinLatency);
          checkOutput("pin_idcode", obsIdcode, pinIdcode);
          checkOutput("pin_lsb_ok", 32'(obsLsb), 32'(pinLsb));
          checkOutput("pin_open_chain", 32'(obsOpen), 32'(pinOpen));
          if (pinRti) checkOutput("tap_in_rti", 32'(tapState), 32'(RTI));
        end
      end
      prevTck = obsTck;
    end
  end

  // ---------------- stimulus ----------------
  // Runs one read; actAge/actKind fire a mid-run start (0) or reset (1) at that model age.
  task automatic applyStimulus(input bit useDiv3, input logic [31:0] id, input int mode,
                               input bit preset, input bit spam, input bit startAtDone,
                               input int actAge, input int actKind,
                               input bit pin, input logic [31:0] pId, input logic pLsb,
                               input logic pOpen, input int pLat, input bit pRti);
    int guard;
    sel        = useDiv3;
    targetId   = id;
    tdoMode    = mode;
    pinValid   = pin;
    pinIdcode  = pId;
    pinLsb     = pLsb;
    pinOpen    = pOpen;
    pinLatency = pLat;
    pinRti     = pRti;
    if (preset) presetReq++;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (modelActive && guard < 2000) begin
      @(posedge clk); #1;
      start = 1'b0;
      reset = 1'b0;
      if (spam && $urandom_range(0, 15) == 0) start = 1'b1;
      if (startAtDone && modelActive && modelAge == SEQ_EDGES * 2 * modelDiv + 1) start = 1'b1;
      if (modelActive && modelAge == actAge) begin
        if (actKind == 0) start = 1'b1;
        else              reset = 1'b1;
      end
      guard++;
    end
    if (guard >= 2000) checkOutput("run_finished", 32'(modelActive), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pinValid = 1'b0;
    pinRti   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] basic read, TCK_DIV=2");
    applyStimulus(0, 32'h1234_5679, 0, 0, 0, 0, -1, 0, 1, 32'h1234_5679, 1'b1, 1'b0, 174, 1);

    $display("[TB] second start at rise 20 while busy");
    applyStimulus(0, 32'h1234_5679, 0, 0, 0, 0, 2 + 19 * 4, 0, 1, 32'h1234_5679, 1'b1, 1'b0, 174, 1);

    $display("[TB] tdo tied high, then tied low");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, -1, 0, 1, 32'hFFFF_FFFF, 1'b1, 1'b1, 174, 0);
    applyStimulus(0, 32'h0, 2, 0, 0, 0, -1, 0, 1, 32'h0000_0000, 1'b0, 1'b0, 174, 0);

    $display("[TB] reset during shift at rise 25, then fresh read");
    applyStimulus(0, 32'hCAFE_F00D, 0, 0, 0, 0, 2 + 24 * 4, 1, 0, 32'h0, 1'b0, 1'b0, 0, 0);
    applyStimulus(0, 32'h1234_5679, 0, 0, 0, 0, -1, 0, 1, 32'h1234_5679, 1'b1, 1'b0, 174, 1);

    $display("[TB] start coincident with done");
    applyStimulus(0, 32'h8765_4321, 0, 0, 0, 1, -1, 0, 1, 32'h8765_4321, 1'b1, 1'b0, 174, 1);

    $display("[TB] start and reset together");
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (6) @(posedge clk);

    $display("[TB] target pre-left in Shift-IR, TCK_DIV=3");
    applyStimulus(1, 32'h0BA0_0477, 0, 1, 0, 0, -1, 0, 1, 32'h0BA0_0477, 1'b1, 1'b0, 260, 1);

    $display("[TB] randomized reads");
    for (int r = 0; r < 8; r++) begin
      int m;
      m = $urandom_range(0, 3);
      if (m == 3) m = 0;
      applyStimulus(1'($urandom_range(0, 1)), $urandom, m, 1'($urandom_range(0, 1)), 1, 0,
                    -1, 0, 0, 32'h0, 1'b0, 1'b0, 0, 0);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
